// File: rtl/ahb_reg_addr_decoder.sv
// AHB-Lite address-phase front end for the register slave: qualifies requests,
// validates size/alignment/index/read-only rules and captures data-phase attributes.
module ahb_reg_addr_decoder #(
    parameter int                ADDR_WIDTH    = 12,
    parameter int                NUM_REGS      = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 16'h0000,
    parameter int                ERR_CNT_WIDTH = 8,
    localparam int               IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     h_sel,
    input  logic [1:0]               h_trans,
    input  logic [ADDR_WIDTH-1:0]    h_addr,
    input  logic                     h_write,
    input  logic [2:0]               h_size,
    input  logic                     h_ready,
    output logic                     req_in,
    output logic                     error,
    output logic [IDX_W-1:0]         reg_idx,
    output logic                     reg_write,
    output logic [3:0]               byte_strb,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic [ADDR_WIDTH-3:0]    w_word;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_oor;
    logic                     w_ro;
    logic                     w_misalign;
    logic                     w_err;
    logic                     w_req;
    logic [3:0]               w_strb;

    logic                     r_dp_valid;
    logic                     r_err_q;
    logic [IDX_W-1:0]         r_reg_idx;
    logic                     r_reg_write;
    logic [3:0]               r_byte_strb;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    assign w_word     = h_addr[ADDR_WIDTH-1:2];
    assign w_idx      = h_addr[IDX_W+1:2];
    assign w_oor      = 32'(w_word) >= 32'(NUM_REGS);
    // The read-only lookup is masked by the range check so RO_MASK is never indexed past its end.
    assign w_ro       = h_write & ~w_oor & RO_MASK[w_idx];
    assign w_misalign = ((h_size == 3'd1) & h_addr[0]) |
                        ((h_size == 3'd2) & (h_addr[1:0] != 2'b00));
    assign w_err      = (h_size > 3'd2) | w_misalign | w_oor | w_ro;
    assign w_req      = h_sel & h_trans[1] & h_ready;

    always_comb begin
        w_strb = 4'b0000;
        case (h_size)
            3'd0:    w_strb = 4'b0001 << h_addr[1:0];
            3'd1:    w_strb = 4'b0011 << {h_addr[1], 1'b0};
            3'd2:    w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    // Capture only on HREADY so wait-stated data phases (and the ERROR cycle) hold their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_valid  <= 1'b0;
            r_err_q     <= 1'b0;
            r_reg_idx   <= '0;
            r_reg_write <= 1'b0;
            r_byte_strb <= 4'b0000;
            r_err_count <= '0;
        end else if (h_ready) begin
            r_dp_valid  <= w_req;
            r_err_q     <= w_req & w_err;
            r_reg_idx   <= w_idx;
            r_reg_write <= h_write;
            r_byte_strb <= (w_req & ~w_err) ? w_strb : 4'b0000;
            if (w_req & w_err & ~(&r_err_count))
                r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
        end
    end

    assign req_in    = w_req;
    assign error     = r_dp_valid & r_err_q;
    assign reg_idx   = r_reg_idx;
    assign reg_write = r_reg_write;
    assign byte_strb = r_byte_strb;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_ahb_reg_addr_decoder.sv
// Bench for ahb_reg_addr_decoder: directed vector table, saturation run and
// randomized traffic against a byte-arithmetic reference model.
module tb_ahb_reg_addr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sel;
    logic [1:0]  h_trans;
    logic [11:0] h_addr;
    logic        h_write;
    logic [2:0]  h_size;
    logic        h_ready;

    logic        req_in,  req_in_ro;
    logic        error,   error_ro;
    logic [3:0]  reg_idx, reg_idx_ro;
    logic        reg_write, reg_write_ro;
    logic [3:0]  byte_strb, byte_strb_ro;
    logic [7:0]  err_count, err_count_ro;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_reg_addr_decoder #(.ADDR_WIDTH(12), .NUM_REGS(16), .RO_MASK(16'h0000), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .h_sel(h_sel), .h_trans(h_trans), .h_addr(h_addr),
        .h_write(h_write), .h_size(h_size), .h_ready(h_ready),
        .req_in(req_in), .error(error), .reg_idx(reg_idx), .reg_write(reg_write),
        .byte_strb(byte_strb), .err_count(err_count)
    );

    ahb_reg_addr_decoder #(.ADDR_WIDTH(12), .NUM_REGS(16), .RO_MASK(16'h0004), .ERR_CNT_WIDTH(8)) dut_ro (
        .clk(clk), .reset(reset), .h_sel(h_sel), .h_trans(h_trans), .h_addr(h_addr),
        .h_write(h_write), .h_size(h_size), .h_ready(h_ready),
        .req_in(req_in_ro), .error(error_ro), .reg_idx(reg_idx_ro), .reg_write(reg_write_ro),
        .byte_strb(byte_strb_ro), .err_count(err_count_ro)
    );

    // Reference model state, index 0 = no read-only regs, index 1 = register 2 read-only.
    int m_dpv[2], m_err[2], m_idx[2], m_wr[2], m_strb[2], m_cnt[2];
    int ro_mask[2] = '{32'h0000, 32'h0004};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_req();
        return (h_sel && h_trans >= 2 && h_ready) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int a, bytes, word, e, req;
        a     = int'(h_addr);
        bytes = 1 << int'(h_size);
        word  = a / 4;
        req   = exp_req();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_dpv[k] = 0; m_err[k] = 0; m_idx[k] = 0; m_wr[k] = 0; m_strb[k] = 0; m_cnt[k] = 0;
            end else if (h_ready) begin
                e = (h_size > 2) || (a % bytes != 0) || (word >= 16) ||
                    (h_write && word < 16 && ((ro_mask[k] >> word) & 1) == 1);
                m_dpv[k]  = req;
                m_err[k]  = req && e;
                m_idx[k]  = word % 16;
                m_wr[k]   = int'(h_write);
                m_strb[k] = (req && !e) ? (((1 << bytes) - 1) << (a % 4)) & 15 : 0;
                if (req && e && m_cnt[k] < 255) m_cnt[k]++;
            end
        end
    endtask

    task automatic check_model();
        chk("error",     int'(error),        m_dpv[0] & m_err[0]);
        chk("byte_strb", int'(byte_strb),    m_strb[0]);
        chk("reg_idx",   int'(reg_idx),      m_idx[0]);
        chk("reg_write", int'(reg_write),    m_wr[0]);
        chk("err_count", int'(err_count),    m_cnt[0]);
        chk("ro_error",  int'(error_ro),     m_dpv[1] & m_err[1]);
        chk("ro_strb",   int'(byte_strb_ro), m_strb[1]);
        chk("ro_count",  int'(err_count_ro), m_cnt[1]);
    endtask

    // One bus cycle: inputs already driven; check req_in, clock, update model, check outputs.
    task automatic step(input logic rst, input logic sel, input logic [1:0] tr, input logic [11:0] ad,
                        input logic wr, input logic [2:0] sz, input logic rdy, input logic verbose);
        reset = rst; h_sel = sel; h_trans = tr; h_addr = ad; h_write = wr; h_size = sz; h_ready = rdy;
        #2;
        chk("req_in",    int'(req_in),    exp_req());
        chk("ro_req_in", int'(req_in_ro), exp_req());
        if (verbose)
            $display("txn rst=%0d sel=%0d trans=%0d addr=%03h wr=%0d size=%0d rdy=%0d req=%0d",
                     rst, sel, tr, ad, wr, sz, rdy, req_in);
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rst, sel;
        logic [1:0]  trans;
        logic [11:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic        rdy;
        int          e_req, e_err, e_err_ro, e_strb, e_idx, e_wr, e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic sel, input logic [1:0] tr, input logic [11:0] ad,
                                input logic wr, input logic [2:0] sz, input logic rdy,
                                input int rq, input int er, input int erro, input int st,
                                input int ix, input int w, input int cn);
        vec_t v;
        v.rst = rst; v.sel = sel; v.trans = tr; v.addr = ad; v.wr = wr; v.size = sz; v.rdy = rdy;
        v.e_req = rq; v.e_err = er; v.e_err_ro = erro; v.e_strb = st; v.e_idx = ix; v.e_wr = w; v.e_cnt = cn;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        //            rst sel tr     addr    wr sz   rdy  req err ero strb idx wr cnt
        tbl[0]  = mk(1, 0, 2'b00, 12'h000, 0, 3'd0, 1,   0,  0,  0,  0,   0,  0, 0);
        tbl[1]  = mk(0, 1, 2'b10, 12'h008, 1, 3'd2, 1,   1,  0,  1,  15,  2,  1, 0);
        tbl[2]  = mk(0, 1, 2'b10, 12'h013, 0, 3'd0, 1,   1,  0,  0,  8,   4,  0, 0);
        tbl[3]  = mk(0, 1, 2'b11, 12'h016, 0, 3'd1, 1,   1,  0,  0,  12,  5,  0, 0);
        tbl[4]  = mk(0, 1, 2'b10, 12'h001, 0, 3'd1, 1,   1,  1,  1,  0,   0,  0, 1);
        tbl[5]  = mk(0, 0, 2'b00, 12'h000, 0, 3'd0, 0,   0,  1,  1,  0,   0,  0, 1);
        tbl[6]  = mk(0, 0, 2'b00, 12'h000, 0, 3'd0, 1,   0,  0,  0,  0,   0,  0, 1);
        tbl[7]  = mk(0, 1, 2'b10, 12'h008, 0, 3'd2, 1,   1,  0,  0,  15,  2,  0, 1);
        tbl[8]  = mk(0, 1, 2'b10, 12'h040, 1, 3'd2, 1,   1,  1,  1,  0,   0,  1, 2);
        tbl[9]  = mk(0, 1, 2'b10, 12'h000, 0, 3'd3, 1,   1,  1,  1,  0,   0,  0, 3);
        tbl[10] = mk(0, 1, 2'b10, 12'h00C, 1, 3'd2, 1,   1,  0,  0,  15,  3,  1, 3);
        tbl[11] = mk(1, 1, 2'b00, 12'h000, 0, 3'd0, 1,   0,  0,  0,  0,   0,  0, 0);
        tbl[12] = mk(0, 1, 2'b01, 12'h000, 0, 3'd0, 1,   0,  0,  0,  0,   0,  0, 0);

        reset = 1'b1; h_sel = 1'b0; h_trans = 2'b00; h_addr = '0; h_write = 1'b0; h_size = 3'd0; h_ready = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; h_sel = tbl[i].sel; h_trans = tbl[i].trans; h_addr = tbl[i].addr;
            h_write = tbl[i].wr; h_size = tbl[i].size; h_ready = tbl[i].rdy;
            #2;
            chk($sformatf("v%0d_req", i), int'(req_in), tbl[i].e_req);
            $display("txn v%0d rst=%0d sel=%0d trans=%0d addr=%03h wr=%0d size=%0d rdy=%0d",
                     i, tbl[i].rst, tbl[i].sel, tbl[i].trans, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].rdy);
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("v%0d_error", i),  int'(error),     tbl[i].e_err);
            chk($sformatf("v%0d_ro_err", i), int'(error_ro),  tbl[i].e_err_ro);
            chk($sformatf("v%0d_strb", i),   int'(byte_strb), tbl[i].e_strb);
            chk($sformatf("v%0d_idx", i),    int'(reg_idx),   tbl[i].e_idx);
            chk($sformatf("v%0d_wr", i),     int'(reg_write), tbl[i].e_wr);
            chk($sformatf("v%0d_cnt", i),    int'(err_count), tbl[i].e_cnt);
            check_model();
        end

        // Saturation: 300 rejected transfers back to back, counter must stick at 255.
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'b1, 2'b10, 12'h000, 1'b0, 3'd3, 1'b1, 1'b0);
        chk("sat_count", int'(err_count), 255);
        chk("sat_error", int'(error), 1);
        $display("txn saturation run of 300 rejected transfers, err_count=%0d", err_count);

        // Wait-stated error phase: count must not move while HREADY is low.
        step(1'b1, 1'b0, 2'b00, 12'h000, 1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 2'b10, 12'h003, 1'b1, 3'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'b10, 12'h004, 1'b0, 3'd2, 1'b0, 1'b1);
        chk("ws_error", int'(error), 1);
        chk("ws_count", int'(err_count), 1);
        step(1'b0, 1'b1, 2'b10, 12'h004, 1'b0, 3'd2, 1'b1, 1'b1);
        chk("ws_clean_error", int'(error), 0);
        chk("ws_clean_strb", int'(byte_strb), 15);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] ad;
            ad = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 8'h4F));
            step(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), ad, 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) != 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
